// File: rtl/interrupt_sequencer.sv
// PC-redirect sequencer: boot-vector load, interrupt entry (drain, push PC/flags, vector fetch)
// and RTI return (pop flags/PC). Owns the PC-load mux select and the data-memory port while busy.
module interrupt_sequencer #(
    parameter int                 DATA_W         = 16,
    parameter int                 FLAG_W         = 4,
    parameter int                 DRAIN_CYCLES   = 3,
    parameter logic [DATA_W-1:0]  RESET_VEC_ADDR = DATA_W'(0),
    parameter logic [DATA_W-1:0]  IRQ_VEC_ADDR   = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_in,
    input  logic              rti_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [DATA_W-1:0] sp_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              sp_dec,
    output logic              sp_inc,
    output logic              stall_fetch,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_load_val,
    output logic              flush,
    output logic              flags_restore,
    output logic [FLAG_W-1:0] flags_out,
    output logic              irq_ack,
    output logic              busy
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_BOOT, S_BOOT_W, S_RUN, S_DRAIN, S_PUSH_PC, S_PUSH_F,
        S_VEC, S_VEC_W, S_POP_F, S_POP_PC, S_POP_W
    } state_t;

    state_t             state_q, state_d;
    logic               irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  saved_pc_q, saved_pc_d;
    logic [FLAG_W-1:0]  saved_flags_q, saved_flags_d;
    logic [DATA_W-1:0]  sp_plus1;

    // Pops read the word just above the next-free slot; wraps modulo 2^DATA_W.
    assign sp_plus1 = sp_in + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            irq_pend_q    <= 1'b0;
            cnt_q         <= '0;
            saved_pc_q    <= '0;
            saved_flags_q <= '0;
        end else begin
            state_q       <= state_d;
            irq_pend_q    <= irq_pend_d;
            cnt_q         <= cnt_d;
            saved_pc_q    <= saved_pc_d;
            saved_flags_q <= saved_flags_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        saved_pc_d    = saved_pc_q;
        saved_flags_d = saved_flags_q;
        // A still-asserted level request re-pends even while the current one is being pushed.
        irq_pend_d    = irq_in | (irq_pend_q & (state_q != S_PUSH_PC));

        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        sp_dec        = 1'b0;
        sp_inc        = 1'b0;
        pc_load       = 1'b0;
        pc_load_val   = '0;
        flush         = 1'b0;
        flags_restore = 1'b0;
        flags_out     = '0;
        irq_ack       = 1'b0;
        busy          = (state_q != S_RUN);
        stall_fetch   = (state_q != S_RUN);

        unique case (state_q)
            S_BOOT: begin
                mem_re   = 1'b1;
                mem_addr = RESET_VEC_ADDR;
                state_d  = S_BOOT_W;
            end
            S_BOOT_W, S_VEC_W, S_POP_W: begin
                pc_load     = 1'b1;
                pc_load_val = mem_rdata;
                flush       = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (rti_in) begin
                    state_d = S_POP_F;
                end else if (irq_pend_q) begin
                    state_d       = S_DRAIN;
                    saved_pc_d    = pc_in;
                    saved_flags_d = flags_in;
                    cnt_d         = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_PUSH_PC;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_PUSH_PC: begin
                mem_we    = 1'b1;
                mem_addr  = sp_in;
                mem_wdata = saved_pc_q;
                sp_dec    = 1'b1;
                irq_ack   = 1'b1;
                state_d   = S_PUSH_F;
            end
            S_PUSH_F: begin
                mem_we    = 1'b1;
                mem_addr  = sp_in;
                mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, saved_flags_q};
                sp_dec    = 1'b1;
                state_d   = S_VEC;
            end
            S_VEC: begin
                mem_re   = 1'b1;
                mem_addr = IRQ_VEC_ADDR;
                state_d  = S_VEC_W;
            end
            S_POP_F: begin
                mem_re   = 1'b1;
                mem_addr = sp_plus1;
                sp_inc   = 1'b1;
                state_d  = S_POP_PC;
            end
            S_POP_PC: begin
                mem_re        = 1'b1;
                mem_addr      = sp_plus1;
                sp_inc        = 1'b1;
                flags_restore = 1'b1;
                flags_out     = mem_rdata[FLAG_W-1:0];
                state_d       = S_POP_W;
            end
            default: state_d = S_BOOT;
        endcase

        // While reset is held the outputs go quiet immediately, not at the next edge.
        if (!reset) begin
            mem_addr      = '0;
            mem_wdata     = '0;
            mem_we        = 1'b0;
            mem_re        = 1'b0;
            sp_dec        = 1'b0;
            sp_inc        = 1'b0;
            pc_load       = 1'b0;
            pc_load_val   = '0;
            flush         = 1'b0;
            flags_restore = 1'b0;
            flags_out     = '0;
            irq_ack       = 1'b0;
            stall_fetch   = 1'b0;
            busy          = 1'b1;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: boot, IRQ entry, RTI, RTI+IRQ priority, SP wrap and
// mid-sequence reset, with a word-addressed memory and SP register modelled in the bench.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_in, rti_in;
    logic [15:0] pc_in, sp_in, mem_rdata;
    logic [3:0]  flags_in;
    logic [15:0] mem_addr, mem_wdata, pc_load_val;
    logic        mem_we, mem_re, sp_dec, sp_inc, stall_fetch, pc_load, flush;
    logic        flags_restore, irq_ack, busy;
    logic [3:0]  flags_out;

    logic [15:0] mem [0:65535];
    logic [15:0] sp;
    int          tests_run = 0;
    int          tests_failed = 0;

    localparam logic [9:0] WE = 10'h200, RE = 10'h100, DEC = 10'h080, INC = 10'h040;
    localparam logic [9:0] STL = 10'h020, PL = 10'h010, FL = 10'h008, FR = 10'h004;
    localparam logic [9:0] ACK = 10'h002, BSY = 10'h001;
    localparam logic [9:0] LOAD = STL | PL | FL | BSY;

    always #5 clk = ~clk;

    assign sp_in = sp;

    interrupt_sequencer dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .rti_in(rti_in), .pc_in(pc_in),
        .flags_in(flags_in), .sp_in(sp_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .sp_dec(sp_dec),
        .sp_inc(sp_inc), .stall_fetch(stall_fetch), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .flush(flush), .flags_restore(flags_restore),
        .flags_out(flags_out), .irq_ack(irq_ack), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    task automatic expect_out(input string tag, input logic [9:0] ctl, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] pcval,
                              input logic [3:0] fl);
        check({tag, ".ctl"}, {22'b0, mem_we, mem_re, sp_dec, sp_inc, stall_fetch, pc_load,
                              flush, flags_restore, irq_ack, busy}, {22'b0, ctl});
        check({tag, ".addr"},  {16'b0, mem_addr},    {16'b0, addr});
        check({tag, ".wdata"}, {16'b0, mem_wdata},   {16'b0, wdata});
        check({tag, ".pcval"}, {16'b0, pc_load_val}, {16'b0, pcval});
        check({tag, ".flags"}, {28'b0, flags_out},   {28'b0, fl});
    endtask

    // Capture strobes at the quiet negedge, apply memory/SP effects just after the rising edge.
    task automatic step();
        logic        we, re, dec, inc;
        logic [15:0] a, w;
        we = mem_we; re = mem_re; dec = sp_dec; inc = sp_inc; a = mem_addr; w = mem_wdata;
        @(posedge clk);
        #1;
        if (we) mem[a] = w;
        if (re) mem_rdata = mem[a];
        if (dec)      sp = sp - 16'd1;
        else if (inc) sp = sp + 16'd1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h0040;
        mem[16'h0001] = 16'h0200;
        mem[16'h0800] = 16'h0005;
        mem[16'h0801] = 16'h0456;
        sp = 16'h07FF; mem_rdata = 16'h0000;
        reset = 1'b0; irq_in = 1'b0; rti_in = 1'b0; pc_in = 16'h0000; flags_in = 4'h0;

        @(negedge clk);
        step();
        expect_out("reset", BSY, 16'h0, 16'h0, 16'h0, 4'h0);

        // Boot
        reset = 1'b1;
        #1;
        expect_out("boot", RE | STL | BSY, 16'h0000, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("boot_w", LOAD, 16'h0, 16'h0, 16'h0040, 4'h0);
        step();
        expect_out("run0", 10'h0, 16'h0, 16'h0, 16'h0, 4'h0);

        // IRQ entry
        pc_in = 16'h0123; flags_in = 4'b1010; irq_in = 1'b1;
        step();
        irq_in = 1'b0;
        expect_out("irq_run", 10'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        step();
        pc_in = 16'hBEEF; flags_in = 4'b0101; rti_in = 1'b1;
        expect_out("drain1", STL | BSY, 16'h0, 16'h0, 16'h0, 4'h0);
        step();
        rti_in = 1'b0;
        expect_out("drain2", STL | BSY, 16'h0, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("drain3", STL | BSY, 16'h0, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("push_pc", WE | DEC | STL | ACK | BSY, 16'h07FF, 16'h0123, 16'h0, 4'h0);
        step();
        expect_out("push_f", WE | DEC | STL | BSY, 16'h07FE, 16'h000A, 16'h0, 4'h0);
        step();
        expect_out("vec", RE | STL | BSY, 16'h0001, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("vec_w", LOAD, 16'h0, 16'h0, 16'h0200, 4'h0);
        step();
        expect_out("irq_ret_run", 10'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        check("stack_pc", {16'b0, mem[16'h07FF]}, 32'h0123);
        check("stack_fl", {16'b0, mem[16'h07FE]}, 32'h000A);
        check("sp_after_push", {16'b0, sp}, 32'h07FD);

        // RTI
        rti_in = 1'b1;
        step();
        rti_in = 1'b0;
        expect_out("pop_f", RE | INC | STL | BSY, 16'h07FE, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("pop_pc", RE | INC | STL | FR | BSY, 16'h07FF, 16'h0, 16'h0, 4'b1010);
        step();
        expect_out("pop_w", LOAD, 16'h0, 16'h0, 16'h0123, 4'h0);
        step();
        expect_out("rti_run", 10'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        check("sp_after_pop", {16'b0, sp}, 32'h07FF);

        // RTI and IRQ in the same cycle: return first, then interrupt
        pc_in = 16'h0300; flags_in = 4'b0011; rti_in = 1'b1; irq_in = 1'b1;
        step();
        rti_in = 1'b0; irq_in = 1'b0;
        expect_out("both_pop_f", RE | INC | STL | BSY, 16'h0800, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("both_pop_pc", RE | INC | STL | FR | BSY, 16'h0801, 16'h0, 16'h0, 4'h5);
        step();
        expect_out("both_pop_w", LOAD, 16'h0, 16'h0, 16'h0456, 4'h0);
        step();
        pc_in = 16'h0456;
        expect_out("both_run", 10'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("both_drain", STL | BSY, 16'h0, 16'h0, 16'h0, 4'h0);
        step();
        step();
        step();
        irq_in = 1'b1;
        expect_out("both_push_pc", WE | DEC | STL | ACK | BSY, 16'h0801, 16'h0456, 16'h0, 4'h0);
        step();
        expect_out("both_push_f", WE | DEC | STL | BSY, 16'h0800, 16'h0003, 16'h0, 4'h0);

        // Async reset in PUSH_F with a request pending
        reset = 1'b0; irq_in = 1'b0;
        #1;
        expect_out("mid_reset", BSY, 16'h0, 16'h0, 16'h0, 4'h0);
        step();
        step();
        check("partial_push_kept", {16'b0, mem[16'h0801]}, 32'h0456);
        check("aborted_push_f", {16'b0, mem[16'h0800]}, 32'h0005);
        check("sp_after_abort", {16'b0, sp}, 32'h0800);
        reset = 1'b1;
        #1;
        expect_out("reboot", RE | STL | BSY, 16'h0000, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("reboot_w", LOAD, 16'h0, 16'h0, 16'h0040, 4'h0);
        step();
        step();
        expect_out("pend_cleared", 10'h0, 16'h0, 16'h0, 16'h0, 4'h0);

        // SP wrap on pop
        sp = 16'hFFFF; rti_in = 1'b1;
        step();
        rti_in = 1'b0;
        expect_out("wrap_pop_f", RE | INC | STL | BSY, 16'h0000, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("wrap_pop_pc", RE | INC | STL | FR | BSY, 16'h0001, 16'h0, 16'h0, 4'h0);
        step();
        expect_out("wrap_pop_w", LOAD, 16'h0, 16'h0, 16'h0200, 4'h0);
        step();
        check("wrap_sp", {16'b0, sp}, 32'h0001);
        check("wrap_busy", {31'b0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
